counter_mode_controller: RTL and testbench

COUNTER_MODE_CONTROLLER -- requirements
Module: counter_mode_controller

---
 rtl/counter_mode_controller_pkg.sv | 15 +
 rtl/counter_mode_controller_button.sv | 45 ++++
 rtl/counter_mode_controller.sv | 91 +++++++++
 tb/tb_counter_mode_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/counter_mode_controller_pkg.sv
// counter_mode_controller_pkg: shared FSM state encodings and counter S-code constants
//   mode_t  : FSM states, also driven onto the Mode LEDs
//   S_*     : {S1,S0} codes presented to the universal counter
package counter_mode_controller_pkg;
   typedef enum logic [1:0] {
      HOLD = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10,
      LOAD = 2'b11
   } mode_t;
   localparam logic [1:0] S_HOLD = 2'b00;
   localparam logic [1:0] S_UP   = 2'b01;
   localparam logic [1:0] S_DOWN = 2'b10;
   localparam logic [1:0] S_LOAD = 2'b11;
endpackage

// File: rtl/counter_mode_controller_button.sv
// button_debouncer: 2-FF synchronizer, debouncer and rising-edge press pulse for one button
//   CLOCK  : system clock, rising edge
//   Reset  : asynchronous, active-high
//   raw    : raw asynchronous pushbutton
//   press  : one-cycle pulse per debounced 0->1 transition
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic CLOCK,
   input  logic Reset,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    sync;
   logic          level;
   logic          level_q;
   logic          rise;
   logic [CW-1:0] cnt;
   // cnt counts consecutive cycles where the synchronized input disagrees with
   // level; the extra rise->press stage lands the pulse DEBOUNCE_CYCLES+3
   // edges after the first edge that samples raw high
   always_ff @(posedge CLOCK or posedge Reset) begin
      if (Reset) begin
         sync    <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         rise    <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync    <= {sync[0], raw};
         level_q <= level;
         rise    <= level & ~level_q;
         press   <= rise;
         if (sync[1] == level)
            cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else
            cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/counter_mode_controller.sv
// counter_mode_controller: debounced button FSM selecting the mode of a universal counter
//   CLOCK, Reset              : system clock (rising) and asynchronous active-high reset
//   BtnUp/BtnDown/BtnHold/BtnLoad : raw pushbuttons
//   Switches                  : raw parallel-load value
//   S1, S0                    : counter mode select, pulsed with Tick in UP/DOWN
//   P                         : registered parallel-load value
//   Mode                      : current FSM state for LEDs
//   Tick                      : one-cycle prescaler strobe every TICK_DIV cycles
module counter_mode_controller
   import counter_mode_controller_pkg::*;
#(
   parameter int LENGTH          = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TICK_DIV        = 50000000
) (
   input  logic              CLOCK,
   input  logic              Reset,
   input  logic              BtnUp,
   input  logic              BtnDown,
   input  logic              BtnHold,
   input  logic              BtnLoad,
   input  logic [LENGTH-1:0] Switches,
   output logic              S1,
   output logic              S0,
   output logic [LENGTH-1:0] P,
   output logic [1:0]        Mode,
   output logic              Tick
);
   localparam int PW = $clog2(TICK_DIV + 1);
   logic [PW-1:0]     presc;
   logic [PW-1:0]     presc_next;
   logic              press_up;
   logic              press_down;
   logic              press_hold;
   logic              press_load;
   logic [LENGTH-1:0] sw_s1;
   logic [LENGTH-1:0] sw_s2;
   mode_t             state;
   mode_t             state_next;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up   (.CLOCK(CLOCK), .Reset(Reset), .raw(BtnUp),   .press(press_up));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (.CLOCK(CLOCK), .Reset(Reset), .raw(BtnDown), .press(press_down));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold (.CLOCK(CLOCK), .Reset(Reset), .raw(BtnHold), .press(press_hold));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (.CLOCK(CLOCK), .Reset(Reset), .raw(BtnLoad), .press(press_load));

   // Tick is registered from the next count so it is high exactly while
   // presc == TICK_DIV-1 without a combinational decode glitch
   assign presc_next = (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;

   always_ff @(posedge CLOCK or posedge Reset) begin
      if (Reset) begin
         presc <= '0;
         Tick  <= 1'b0;
      end else begin
         presc <= presc_next;
         Tick  <= presc_next == PW'(TICK_DIV - 1);
      end
   end

   always_ff @(posedge CLOCK or posedge Reset) begin
      if (Reset) begin
         state <= HOLD;
         sw_s1 <= '0;
         sw_s2 <= '0;
         P     <= '0;
      end else begin
         state <= state_next;
         sw_s1 <= Switches;
         sw_s2 <= sw_s1;
         if (state != LOAD && press_load)
            P <= sw_s2;
      end
   end

   // LOAD lasts one cycle and swallows any presses; otherwise priority
   // Load > Hold > Down > Up
   always_comb begin
      state_next = state == LOAD ? HOLD
                 : press_load    ? LOAD
                 : press_hold    ? HOLD
                 : press_down    ? DOWN
                 : press_up      ? UP
                 : state;
      {S1, S0}   = state == UP   ? (S_UP & {2{Tick}})
                 : state == DOWN ? (S_DOWN & {2{Tick}})
                 : state == LOAD ? S_LOAD
                 : S_HOLD;
   end

   assign Mode = state;
endmodule

// File: tb/tb_counter_mode_controller.sv
// tb_counter_mode_controller: scoreboard bench for counter_mode_controller (DEBOUNCE_CYCLES=4, TICK_DIV=5)
module tb_counter_mode_controller;
   import counter_mode_controller_pkg::*;

   typedef struct {
      int         cyc;
      logic [1:0] mode;
      logic [1:0] s;
      logic [3:0] p;
      logic       tick;
      logic [3:0] press;
   } exp_t;

   logic       CLOCK;
   logic       Reset;
   logic       BtnUp;
   logic       BtnDown;
   logic       BtnHold;
   logic       BtnLoad;
   logic [3:0] Switches;
   logic       S1;
   logic       S0;
   logic [3:0] P;
   logic [1:0] Mode;
   logic       Tick;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   exp_t       q[$];

   counter_mode_controller #(.LENGTH(4), .DEBOUNCE_CYCLES(4), .TICK_DIV(5)) dut (
      .CLOCK(CLOCK), .Reset(Reset), .BtnUp(BtnUp), .BtnDown(BtnDown), .BtnHold(BtnHold),
      .BtnLoad(BtnLoad), .Switches(Switches), .S1(S1), .S0(S0), .P(P), .Mode(Mode), .Tick(Tick)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;
   always @(posedge CLOCK) cyc <= cyc + 1;

   task automatic check(string tag, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, want);
      end
   endtask

   // Expected timeline: a button raised just after edge c is first sampled at
   // edge c+1, so its press pulse is visible after edge c+8 (c+1 + 4 + 3).
   function automatic logic [1:0] exp_mode(int c);
      if (c >= 13 && c <= 70) return UP;
      if (c == 71 || c == 99) return LOAD;
      return HOLD;
   endfunction

   function automatic logic [3:0] exp_p(int c);
      if (c >= 71 && c <= 98) return 4'hA;
      if (c >= 99 && c <= 127) return 4'h5;
      return 4'h0;
   endfunction

   // Prescaler restarts at 0 on each release; Tick when 4 edges past release mod 5
   function automatic logic exp_tick(int c);
      int r;
      if (c < 2 || (c >= 128 && c < 131)) return 1'b0;
      r = c >= 131 ? 131 : 2;
      return (c - r) % 5 == 4;
   endfunction

   function automatic logic [1:0] exp_s(logic [1:0] m, logic t);
      if (m == UP) return {1'b0, t};
      if (m == DOWN) return {t, 1'b0};
      if (m == LOAD) return 2'b11;
      return 2'b00;
   endfunction

   // {load, hold, down, up}
   function automatic logic [3:0] exp_press(int c);
      logic [3:0] r;
      r = '0;
      r[0] = c == 12 || c == 98;
      r[1] = c == 99;
      r[2] = c == 139;
      r[3] = c == 70 || c == 98 || c == 127;
      return r;
   endfunction

   always @(negedge CLOCK) begin
      exp_t e;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         check("mode", Mode, e.mode);
         check("s1s0", {S1, S0}, e.s);
         check("p", P, e.p);
         check("tick", Tick, e.tick);
         check("press", {dut.press_load, dut.press_hold, dut.press_down, dut.press_up}, e.press);
      end
   end

   initial begin
      Reset    = 1'b1;
      BtnUp    = 1'b0;
      BtnDown  = 1'b0;
      BtnHold  = 1'b0;
      BtnLoad  = 1'b0;
      Switches = 4'h0;
      @(posedge CLOCK);
      #1;
      for (int c = 1; c <= 145; c++) begin
         exp_t e;
         // release at 2; reset mid-LOAD at 128, released at 131
         Reset    = c < 2 || (c >= 128 && c < 131);
         // Up held 20 cycles, then Up+Load together at 90
         BtnUp    = (c >= 4 && c < 24) || (c >= 90 && c < 105);
         // bounce every 2 cycles for 12 cycles, then a press landing inside LOAD
         BtnDown  = (c >= 40 && c < 52 && ((c - 40) / 2) % 2 == 0) || (c >= 91 && c < 105);
         BtnLoad  = (c >= 62 && c < 75) || (c >= 90 && c < 105) || (c >= 119 && c < 128);
         // held through the second reset release
         BtnHold  = c >= 125;
         Switches = c >= 110 ? 4'h3 : c >= 85 ? 4'h5 : c >= 60 ? 4'hA : 4'h0;
         e.cyc   = c;
         e.mode  = exp_mode(c);
         e.tick  = exp_tick(c);
         e.s     = exp_s(e.mode, e.tick);
         e.p     = exp_p(c);
         e.press = exp_press(c);
         q.push_back(e);
         @(posedge CLOCK);
         #1;
      end
      check("drain", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
